// File: rtl/bill_pkg.sv
// Shared types and default thresholds for the bill acceptor.
package bill_pkg;

    // Acceptor control states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MEASURE = 3'd1,
        HOLD    = 3'd2,
        ISSUE   = 3'd3,
        REJECT  = 3'd4
    } state_t;

    // Denomination currently held in escrow
    typedef enum logic [1:0] {
        NONE   = 2'd0,
        TEN    = 2'd1,
        TWENTY = 2'd2
    } escrow_t;

    // Default pulse-length windows, in clock cycles
    localparam int DEF_CNT_W      = 8;
    localparam int DEF_TEN_MIN    = 20;
    localparam int DEF_TEN_MAX    = 40;
    localparam int DEF_TWENTY_MIN = 60;
    localparam int DEF_TWENTY_MAX = 80;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for the asynchronous slot sensor.
module sync2 (
    input  logic clk,
    input  logic clear,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage resynchronization into the clk domain
    always_ff @(posedge clk) begin
        if (clear) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bill_acceptor.sv
// Bill acceptor: measures the sensor pulse length, classifies the bill as
// $10 / $20 / reject, escrows it until the ticket machine opens its window,
// then emits a single one-cycle credit or reject pulse.
module bill_acceptor
    import bill_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int TEN_MIN    = DEF_TEN_MIN,
    parameter int TEN_MAX    = DEF_TEN_MAX,
    parameter int TWENTY_MIN = DEF_TWENTY_MIN,
    parameter int TWENTY_MAX = DEF_TWENTY_MAX
) (
    input  logic clk,
    input  logic clear,
    input  logic sense,
    input  logic ready,
    input  logic bill,
    output logic ten,
    output logic twenty,
    output logic reject,
    output logic busy
);

    // Windows must be ordered and the longest accepted length must stay
    // below the saturation value, so a saturated count always rejects.
    if (!(TEN_MIN <= TEN_MAX && TEN_MAX < TWENTY_MIN &&
          TWENTY_MIN <= TWENTY_MAX && TWENTY_MAX < (2 ** CNT_W) - 1)) begin : g_bad_params
        $error("bill_acceptor: threshold parameters out of order or too wide for CNT_W");
    end

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] L_TEN_LO  = CNT_W'(TEN_MIN);
    localparam logic [CNT_W-1:0] L_TEN_HI  = CNT_W'(TEN_MAX);
    localparam logic [CNT_W-1:0] L_TWN_LO  = CNT_W'(TWENTY_MIN);
    localparam logic [CNT_W-1:0] L_TWN_HI  = CNT_W'(TWENTY_MAX);

    logic             s;
    state_t           state, state_nxt;
    escrow_t          escrow, escrow_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             armed, armed_nxt;
    logic             is_ten, is_twenty;

    sync2 u_sync (
        .clk   (clk),
        .clear (clear),
        .d     (sense),
        .q     (s)
    );

    // Length classification straight off the running count
    always_comb begin
        is_ten    = (cnt >= L_TEN_LO) && (cnt <= L_TEN_HI);
        is_twenty = (cnt >= L_TWN_LO) && (cnt <= L_TWN_HI);
    end

    // Next-state, counter, escrow and re-arm logic
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        escrow_nxt = escrow;
        armed_nxt  = armed;
        case (state)
            IDLE: begin
                // A bill still in the slot after its pulse must clear the
                // sensor before another measurement may start.
                if (!s) begin
                    armed_nxt = 1'b1;
                end else if (armed) begin
                    state_nxt = MEASURE;
                    cnt_nxt   = CNT_ONE;
                end
            end
            MEASURE: begin
                if (s) begin
                    if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
                end else if (is_ten) begin
                    escrow_nxt = TEN;
                    state_nxt  = HOLD;
                end else if (is_twenty) begin
                    escrow_nxt = TWENTY;
                    state_nxt  = HOLD;
                end else begin
                    state_nxt  = REJECT;
                end
            end
            HOLD: begin
                if (ready || bill) state_nxt = ISSUE;
            end
            ISSUE: begin
                state_nxt  = IDLE;
                escrow_nxt = NONE;
                cnt_nxt    = '0;
                armed_nxt  = !s;
            end
            REJECT: begin
                state_nxt  = IDLE;
                cnt_nxt    = '0;
                armed_nxt  = !s;
            end
            default: begin
                state_nxt  = IDLE;
                escrow_nxt = NONE;
                cnt_nxt    = '0;
            end
        endcase
    end

    // Moore outputs, forced low while clear is asserted
    always_comb begin
        ten    = 1'b0;
        twenty = 1'b0;
        reject = 1'b0;
        busy   = 1'b0;
        if (!clear) begin
            ten    = (state == ISSUE) && (escrow == TEN);
            twenty = (state == ISSUE) && (escrow == TWENTY);
            reject = (state == REJECT);
            busy   = (state != IDLE);
        end
    end

    // State, counter, escrow and arm registers
    always_ff @(posedge clk) begin
        if (clear) begin
            state  <= IDLE;
            cnt    <= '0;
            escrow <= NONE;
            armed  <= 1'b1;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            escrow <= escrow_nxt;
            armed  <= armed_nxt;
        end
    end

endmodule

// File: tb/tb_bill_acceptor.sv
// Self-checking bench for bill_acceptor: directed threshold cases, window,
// clear and lingering-bill scenarios, plus randomized bills checked against
// a length-to-outcome reference model.
module tb_bill_acceptor;

    logic clk = 1'b0;
    logic clear, sense, ready, bill;
    logic ten, twenty, reject, busy;

    int checks = 0;
    int errors = 0;

    localparam int SAT = 255;

    bill_acceptor dut (
        .clk    (clk),
        .clear  (clear),
        .sense  (sense),
        .ready  (ready),
        .bill   (bill),
        .ten    (ten),
        .twenty (twenty),
        .reject (reject),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then stable and inputs may change
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference: 0 = reject, 1 = $10, 2 = $20
    function automatic int classify(input int len);
        int l;
        l = (len > SAT) ? SAT : len;
        if (l >= 20 && l <= 40) return 1;
        if (l >= 60 && l <= 80) return 2;
        return 0;
    endfunction

    // Insert one bill of len cycles; the window (ready or bill) opens gap
    // cycles after sense falls, or is already open when gap is 0.
    task automatic run_bill(input string tag, input int len, input int gap, input bit use_bill);
        int kind, off, n10, n20, nrj, first, busy_hold, busy_after, span;
        kind = classify(len);
        if (kind == 0)        off = 3;
        else if (gap + 1 > 4) off = gap + 1;
        else                  off = 4;
        if (gap == 0) begin
            ready = !use_bill;
            bill  = use_bill;
        end
        sense = 1'b1;
        repeat (len) cyc();
        sense = 1'b0;
        n10 = 0; n20 = 0; nrj = 0; first = -1; busy_hold = 1; busy_after = 1;
        span = off + 6;
        for (int i = 1; i <= span; i++) begin
            cyc();
            if ((ten | twenty | reject) && first < 0) first = i;
            n10 += int'(ten);
            n20 += int'(twenty);
            nrj += int'(reject);
            if (i <= off) busy_hold = busy_hold & int'(busy);
            if (i == off + 1) busy_after = int'(busy);
            if (gap > 0 && i == gap) begin
                ready = !use_bill;
                bill  = use_bill;
            end
        end
        chk({tag, " ten_count"},    n10, (kind == 1) ? 1 : 0);
        chk({tag, " twenty_count"}, n20, (kind == 2) ? 1 : 0);
        chk({tag, " reject_count"}, nrj, (kind == 0) ? 1 : 0);
        chk({tag, " latency"},      first, off);
        chk({tag, " busy_held"},    busy_hold, 1);
        chk({tag, " busy_after"},   busy_after, 0);
        ready = 1'b0;
        bill  = 1'b0;
        repeat (3) cyc();
    endtask

    initial begin
        int n, first, b5, b12;
        int edges[10] = '{19, 20, 40, 41, 59, 60, 80, 81, 255, 256};

        clear = 1'b1; sense = 1'b0; ready = 1'b0; bill = 1'b0;
        cyc();
        chk("reset busy",   busy, 0);
        chk("reset pulses", {ten, twenty, reject}, 3'b000);
        cyc();
        clear = 1'b0;
        #1;
        chk("post-reset busy",   busy, 0);
        chk("post-reset pulses", {ten, twenty, reject}, 3'b000);
        repeat (2) cyc();

        // Basic credits and threshold edges
        run_bill("ten30",    30,  0, 1'b0);
        run_bill("twenty70", 70,  0, 1'b1);
        run_bill("len19",    19,  0, 1'b0);
        run_bill("len20",    20,  0, 1'b0);
        run_bill("len40",    40,  0, 1'b0);
        run_bill("len50",    50,  0, 1'b0);
        run_bill("len60",    60,  0, 1'b0);
        run_bill("len80",    80,  0, 1'b0);
        run_bill("len81",    81,  0, 1'b0);
        run_bill("len300",   300, 0, 1'b0);

        // Window held closed for 10 cycles
        run_bill("closed", 30, 10, 1'b0);

        // Clear while a $20 sits in escrow
        sense = 1'b1;
        repeat (70) cyc();
        sense = 1'b0;
        repeat (5) cyc();
        chk("clr hold busy", busy, 1);
        clear = 1'b1;
        #1;
        chk("clr busy during", busy, 0);
        cyc();
        clear = 1'b0;
        #1;
        chk("clr busy after", busy, 0);
        ready = 1'b1;
        n = 0;
        repeat (10) begin
            cyc();
            n += int'(ten | twenty | reject);
        end
        chk("clr no pulse", n, 0);
        ready = 1'b0;
        cyc();
        run_bill("clr next", 30, 0, 1'b0);

        // Second pulse during HOLD that lingers past ISSUE
        sense = 1'b1;
        repeat (30) cyc();
        sense = 1'b0;
        n = 0; first = -1; b5 = 0; b12 = 1;
        for (int i = 1; i <= 30; i++) begin
            cyc();
            if (ten && first < 0) first = i;
            n += int'(ten) + int'(twenty) + int'(reject);
            if (i == 5)  b5  = int'(busy);
            if (i == 12) b12 = int'(busy);
            if (i == 4)  sense = 1'b1;
            if (i == 6)  ready = 1'b1;
            if (i == 14) sense = 1'b0;
        end
        chk("linger pulses",    n, 1);
        chk("linger ten cycle", first, 7);
        chk("linger hold busy", b5, 1);
        chk("linger no rearm",  b12, 0);
        ready = 1'b0;
        cyc();
        run_bill("linger next", 20, 0, 1'b0);

        // Randomized bills
        for (int k = 0; k < 20; k++) begin
            int len, gap, sel;
            bit ub;
            sel = int'($urandom_range(0, 3));
            if (sel == 0)      len = edges[$urandom_range(0, 9)];
            else if (sel == 1) len = int'($urandom_range(1, 300));
            else               len = int'($urandom_range(1, 100));
            gap = int'($urandom_range(0, 8));
            ub  = 1'($urandom_range(0, 1));
            run_bill($sformatf("rand%0d len%0d gap%0d", k, len, gap), len, gap, ub);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bill_acceptor.md
BILL_ACCEPTOR -- requirements
Module: bill_acceptor

Interface
REQ-001 Parameter CNT_W, default 8: width of the pulse-length counter.
REQ-002 Parameter TEN_MIN, default 20: shortest accepted $10 sense pulse, in cycles.
REQ-003 Parameter TEN_MAX, default 40: longest accepted $10 sense pulse, in cycles.
REQ-004 Parameter TWENTY_MIN, default 60: shortest accepted $20 sense pulse, in cycles.
REQ-005 Parameter TWENTY_MAX, default 80: longest accepted $20 sense pulse, in cycles.
REQ-006 Parameters SHALL satisfy TEN_MIN<=TEN_MAX<TWENTY_MIN<=TWENTY_MAX<2^CNT_W-1; a violation SHALL be an elaboration error.
REQ-007 clk  input  1  sole clock, rising edge.
REQ-008 clear  input  1  synchronous, active-high reset.
REQ-009 sense  input  1  raw asynchronous bill-slot optical sensor, high while a bill passes.
REQ-010 ready  input  1  ticket-machine ready status.
REQ-011 bill  input  1  ticket-machine bill-accumulating status.
REQ-012 ten  output  1  one-cycle pulse: $10 bill credited.
REQ-013 twenty  output  1  one-cycle pulse: $20 bill credited.
REQ-014 reject  output  1  one-cycle pulse: bill not credited, mechanism ejects it.
REQ-015 busy  output  1  high when the acceptor is not in IDLE; the mechanism blocks the slot while busy.

Function
REQ-016 sense SHALL pass through a two-flop synchronizer; s denotes the synchronized value.
REQ-017 The FSM SHALL have states IDLE, MEASURE, HOLD, ISSUE and REJECT.
REQ-018 In IDLE with s=1, the FSM SHALL go to MEASURE with cnt=1; otherwise it stays in IDLE.
REQ-019 In MEASURE with s=1, cnt SHALL increment and saturate at 2^CNT_W-1.
REQ-020 In MEASURE with s=0, length L=cnt SHALL be classified in that cycle.
- L in [TEN_MIN,TEN_MAX]: escrow=TEN, next state HOLD.
- L in [TWENTY_MIN,TWENTY_MAX]: escrow=TWENTY, next state HOLD.
- Any other L, including saturated: next state REJECT.
REQ-021 In HOLD, the FSM SHALL go to ISSUE when (ready|bill)=1 and stay in HOLD otherwise, for example while the downstream machine is in its dispense or return cycle.
REQ-022 ISSUE SHALL last exactly one cycle, then go to IDLE.
- ten=1 when escrow=TEN.
- twenty=1 when escrow=TWENTY.
REQ-023 REJECT SHALL last exactly one cycle with reject=1, then go to IDLE.
REQ-024 ten, twenty and reject SHALL be Moore outputs, mutually exclusive, and never high for two consecutive cycles.
REQ-025 Fixed latency: from sense falling to the credit pulse is 4 cycles when the window is open (2 synchronizer, 1 classify, 1 HOLD), and 3 cycles to reject=1.
REQ-026 sense activity outside IDLE and MEASURE SHALL be ignored: no measurement and no pulse.
REQ-027 If s is still high when the FSM leaves ISSUE or REJECT, IDLE SHALL wait for s=0 before arming again; a lingering bill is never double-counted.
REQ-028 The escrow SHALL hold at most one bill; the credit SHALL be lost only through clear.

Reset
REQ-029 On clear=1 at a rising edge, all of the following SHALL reset:
- state to IDLE;
- cnt, escrow and both synchronizer flops to 0;
- the "wait for s=0" arm flag to armed.
REQ-030 While clear=1 and in the cycle after it, ten, twenty, reject and busy SHALL be 0.
REQ-031 A clear during MEASURE or HOLD SHALL discard the bill with no credit and no reject pulse.

Structure
REQ-032 A shared package bill_pkg SHALL hold:
- the FSM state enum;
- the escrow denomination enum (NONE, TEN, TWENTY);
- the default threshold constants.
REQ-033 The synchronizer SHALL be a separate sub-module, sync2, with ports clk, clear, d and q.
REQ-034 The classification compare SHALL be combinational on cnt; there SHALL be no divider and no multiplier.

Verification
REQ-035 sense high 30 cycles, ready=1 -> ten=1 for one cycle, 4 cycles after sense falls; twenty=0, reject=0.
REQ-036 sense high 70 cycles, bill=1 -> twenty=1 for one cycle, 4 cycles after sense falls.
REQ-037 The bench SHALL check each threshold edge, with ready=1:
- sense high 19 cycles -> reject;
- sense high 20 cycles -> ten;
- sense high 50 cycles -> reject;
- sense high 81 cycles -> reject;
- sense high 300 cycles (saturated) -> reject.
REQ-038 Window held closed: sense 30 cycles, ready=bill=0 for 10 cycles, then ready=1 -> busy stays 1, ten pulses exactly once, the cycle after ready rises.
REQ-039 clear asserted while in HOLD with escrow=TWENTY -> no twenty pulse; busy=0 after 1 cycle; the next 30-cycle bill -> ten.
REQ-040 Second sense pulse while in HOLD, and sense still high after ISSUE -> exactly one credit, no reject, and re-arm only after sense drops.
